// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle for the multiply/divide unit.
//   md_en, md_op, rs_val, rt_val : request side (driven by the master)
//   busy, md_stall, done, hi, lo : status/results (driven by the unit)
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             md_en;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             md_stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output md_en, md_op, rs_val, rt_val,
    input  busy, md_stall, done, hi, lo
  );

  modport slave (
    input  md_en, md_op, rs_val, rt_val,
    output busy, md_stall, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// The result is computed when the request is accepted and held privately;
// HI/LO only change at the commit edge, MULT_CYCLES or DIV_CYCLES edges later.
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   md_io  : slave side of md_unit_if (request strobe/opcode/operands in;
//            busy, md_stall, done, hi, lo out)
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  md_unit_if.slave    md_io
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;

  logic             is_long_op;

  // One shared multiplier: operands sign- or zero-extended to 2*WIDTH so the
  // low 2*WIDTH bits of the product are correct for both signed and unsigned.
  logic             mul_signed;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;

  // Division on magnitudes, then sign fix-up: quotient truncates toward zero,
  // remainder takes the dividend's sign. Most-negative / -1 falls out as
  // quotient = most-negative, remainder = 0 without a special case.
  logic             div_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic [WIDTH-1:0] quot, rem;

  assign is_long_op = (md_io.md_op == OP_MULT) || (md_io.md_op == OP_MULTU) ||
                      (md_io.md_op == OP_DIV)  || (md_io.md_op == OP_DIVU);

  assign mul_signed = (md_io.md_op == OP_MULT);
  assign mul_a = {{WIDTH{mul_signed & md_io.rs_val[WIDTH-1]}}, md_io.rs_val};
  assign mul_b = {{WIDTH{mul_signed & md_io.rt_val[WIDTH-1]}}, md_io.rt_val};
  assign mul_p = mul_a * mul_b;

  assign div_signed = (md_io.md_op == OP_DIV);
  assign a_neg  = div_signed & md_io.rs_val[WIDTH-1];
  assign b_neg  = div_signed & md_io.rt_val[WIDTH-1];
  assign a_mag  = a_neg ? (~md_io.rs_val + WIDTH'(1)) : md_io.rs_val;
  assign b_mag  = b_neg ? (~md_io.rt_val + WIDTH'(1)) : md_io.rt_val;
  // Keeps the divider free of X on a zero divisor; that result is discarded.
  assign b_safe = (md_io.rt_val == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
  assign rem    = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_en_d  = wr_en_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (md_io.md_en) begin
          case (md_io.md_op)
            OP_MULT, OP_MULTU: begin
              state_d  = ST_BUSY;
              cnt_d    = CntW'(MULT_CYCLES);
              res_hi_d = mul_p[2*WIDTH-1:WIDTH];
              res_lo_d = mul_p[WIDTH-1:0];
              wr_en_d  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = ST_BUSY;
              cnt_d    = CntW'(DIV_CYCLES);
              res_hi_d = rem;
              res_lo_d = quot;
              wr_en_d  = (md_io.rt_val != '0);
            end
            OP_MTHI: hi_d = md_io.rs_val;
            OP_MTLO: lo_d = md_io.rs_val;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        // Requests are dropped here; nothing is queued.
        if (cnt_q == CntW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (wr_en_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
    end
  end

  assign md_io.busy     = (state_q == ST_BUSY);
  assign md_io.md_stall = (state_q == ST_BUSY) || (md_io.md_en && is_long_op);
  assign md_io.done     = done_q;
  assign md_io.hi       = hi_q;
  assign md_io.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized + directed bench for md_unit against a cycle-numbered
// arithmetic reference model.
module tb_md_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) md_io ();

  md_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .md_io(md_io)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_busy, m_done, p_wr;
  longint      cyc, commit_at;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
    m_busy = 0; m_done = 0; p_wr = 0;
    commit_at = 0;
  endtask

  task automatic model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      p, q, r;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin
        p = longint'(sa) * longint'(sb);
        {p_hi, p_lo} = p;
        p_wr = 1;
      end
      3'd2: begin
        u = {32'd0, a} * {32'd0, b};
        {p_hi, p_lo} = u;
        p_wr = 1;
      end
      3'd3: begin
        p_wr = (b != 0);
        if (b != 0) begin
          q = longint'(sa) / longint'(sb);
          r = longint'(sa) % longint'(sb);
          p_lo = 32'(q);
          p_hi = 32'(r);
        end
      end
      default: begin
        p_wr = (b != 0);
        if (b != 0) begin
          p_lo = a / b;
          p_hi = a % b;
        end
      end
    endcase
  endtask

  // Drive one request cycle, check stall, advance an edge, update model, check outputs.
  task automatic cycle(input bit en, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit acc;
    md_io.md_en  = en;
    md_io.md_op  = op;
    md_io.rs_val = a;
    md_io.rt_val = b;
    #1;
    check_eq("md_stall", 64'(md_io.md_stall),
             64'(m_busy || (en && op >= 3'd1 && op <= 3'd4)));
    acc = en && !m_busy && op != 3'd0 && op != 3'd7;
    @(posedge clk);
    cyc++;
    m_done = 0;
    if (m_busy && cyc == commit_at) begin
      if (p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      m_busy = 0;
      m_done = 1;
    end else if (acc) begin
      case (op)
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: begin
          model_compute(op, a, b);
          m_busy = 1;
          commit_at = cyc + ((op <= 3'd2) ? MC : DC);
        end
      endcase
    end
    #1;
    check_eq("busy", 64'(md_io.busy), 64'(m_busy));
    check_eq("done", 64'(md_io.done), 64'(m_done));
    check_eq("hi", 64'(md_io.hi), 64'(m_hi));
    check_eq("lo", 64'(md_io.lo), 64'(m_lo));
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, '0, '0);
  endtask

  // Issue one op and run idle cycles until the model says it has committed.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cycle(1'b1, op, a, b);
    for (int i = 0; i < 20 && m_busy; i++) idle();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_busy", 64'(md_io.busy), 64'd0);
    check_eq("rst_done", 64'(md_io.done), 64'd0);
    check_eq("rst_hi", 64'(md_io.hi), 64'd0);
    check_eq("rst_lo", 64'(md_io.lo), 64'd0);
    md_io.md_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cyc = 0;
    model_reset();
    rst_n        = 1'b0;
    md_io.md_en  = 1'b0;
    md_io.md_op  = 3'd0;
    md_io.rs_val = '0;
    md_io.rt_val = '0;
    #1;
    check_eq("reset_busy", 64'(md_io.busy), 64'd0);
    check_eq("reset_done", 64'(md_io.done), 64'd0);
    check_eq("reset_hi", 64'(md_io.hi), 64'd0);
    check_eq("reset_lo", 64'(md_io.lo), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // MULT -2 * 3, back-to-back MULTU
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    check_eq("mult_hi", 64'(md_io.hi), 64'hFFFF_FFFF);
    check_eq("mult_lo", 64'(md_io.lo), 64'hFFFF_FFFA);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    check_eq("multu_hi", 64'(md_io.hi), 64'h0000_0001);
    check_eq("multu_lo", 64'(md_io.lo), 64'hFFFF_FFFE);
    idle();

    // DIV -7 / 2, then overflow case
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_lo", 64'(md_io.lo), 64'hFFFF_FFFD);
    check_eq("div_hi", 64'(md_io.hi), 64'hFFFF_FFFF);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divovf_lo", 64'(md_io.lo), 64'h8000_0000);
    check_eq("divovf_hi", 64'(md_io.hi), 64'h0);

    // Divide by zero leaves HI/LO alone
    cycle(1'b1, 3'd5, 32'h11, '0);
    cycle(1'b1, 3'd6, 32'h22, '0);
    do_op(3'd4, 32'd100, 32'd0);
    check_eq("divz_hi", 64'(md_io.hi), 64'h11);
    check_eq("divz_lo", 64'(md_io.lo), 64'h22);
    idle();

    // Requests during a DIV window are dropped
    cycle(1'b1, 3'd3, 32'd100, 32'd7);
    cycle(1'b1, 3'd5, 32'h5, '0);
    cycle(1'b1, 3'd1, 32'd3, 32'd4);
    for (int i = 0; i < 20 && m_busy; i++) idle();
    check_eq("ign_hi", 64'(md_io.hi), 64'd2);
    check_eq("ign_lo", 64'(md_io.lo), 64'd14);
    idle();

    // Reset in cycle 3 of a MULT window, then MTLO right after release
    cycle(1'b1, 3'd1, 32'd9, 32'd9);
    idle();
    idle();
    async_reset();
    cycle(1'b1, 3'd6, 32'hABCD, '0);
    check_eq("mtlo_after_rst", 64'(md_io.lo), 64'hABCD);
    for (int i = 0; i < 8; i++) idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick());
    end
    for (int i = 0; i < 20 && m_busy; i++) idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 Parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU (SHALL be >= 1).
REQ-003 Parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU (SHALL be >= 1).
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 md_en  input  1  request strobe, sampled at rising edge.
REQ-008 md_op  input  3  operation code: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
REQ-009 rs_val  input  WIDTH  operand A; also the source for MTHI/MTLO.
REQ-010 rt_val  input  WIDTH  operand B.
REQ-011 busy  output  1  registered; high while a MULT/DIV operation is in flight.
REQ-012 md_stall  output  1  combinational: busy OR (md_en AND md_op in MULT..DIVU).
REQ-013 done  output  1  registered single-cycle pulse on the cycle after HI/LO commit.
REQ-014 hi  output  WIDTH  registered HI value.
REQ-015 lo  output  WIDTH  registered LO value.

Function
REQ-016 Request accepted only at an edge where md_en=1, busy=0, and md_op is not NONE or reserved.
REQ-017 Requests with busy=1 SHALL be ignored entirely: no state change, and no queueing.
REQ-018 NONE/reserved requests SHALL be ignored with no state change.
REQ-019 Accepted MTHI: hi <= rs_val at the accepting edge; busy stays 0; done stays 0.
REQ-020 Accepted MTLO: lo <= rs_val at the accepting edge; busy stays 0; done stays 0.
REQ-021 Accepted MULT/MULTU/DIV/DIVU at edge k: operands/result captured internally at edge k; busy=1 from edge k to edge k+N, where N = MULT_CYCLES or DIV_CYCLES.
REQ-022 Commit edge: at edge k+N, hi/lo load the result and busy returns to 0 together; done=1 for exactly the following cycle.
REQ-023 hi/lo SHALL hold their old values throughout the busy window; rs_val/rt_val changes during the window have no effect.
REQ-024 MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-025 MULTU: unsigned 2*WIDTH product, with the same split as MULT.
REQ-026 DIV: signed division truncating toward zero; lo = quotient; hi = remainder, with remainder sign equal to the dividend sign.
REQ-027 DIVU: unsigned division; lo = quotient, hi = remainder.
REQ-028 Divide by zero (rt_val=0) for DIV/DIVU: full busy window still runs and done pulses, but hi/lo SHALL remain unchanged.
REQ-029 DIV overflow (rs_val = most-negative, rt_val = -1): lo = most-negative, hi = 0.
REQ-030 A new request is accepted at the commit edge's following edge at the earliest (busy=0 then); back-to-back operations SHALL incur no extra idle cycle beyond that.
REQ-031 Internal state: IDLE and BUSY, plus a countdown counter of width clog2(max(MULT_CYCLES, DIV_CYCLES))+1.
REQ-032 Transitions: IDLE->BUSY on an accepted MULT/DIV; BUSY->IDLE when the counter expires (commit).

Reset
REQ-033 rst_n=0 SHALL immediately force busy=0, done=0, hi=0, lo=0, state IDLE, and counter 0, independent of clk.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no commit and no done pulse after release.
REQ-035 First request is accepted at the first rising edge after rst_n deasserts.

Verification
REQ-036 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-037 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-038 DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 DIVU rs=100, rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, done pulses, hi/lo stay 0x11/0x22.
REQ-040 During a DIV busy window, issue MTHI rs=0x5 and MULT -> both ignored; md_stall=1 throughout; final hi/lo equal the DIV result only.
REQ-041 Start MULT, assert rst_n=0 in cycle 3 of the window -> busy/hi/lo read 0 immediately, no done pulse; after release, MTLO rs=0xABCD gives lo=0xABCD the next cycle.
